odo_cdir_sequencer: RTL

ODO_CDIR_SEQUENCER -- requirements
Module: odo_cdir_sequencer

---
 rtl/odo_pkg.sv | 20 ++
 rtl/odo_phase_timer.sv | 36 +++
 rtl/odo_cdir_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/odo_pkg.sv
// rtl/odo_pkg.sv - shared state, mode encodings and defaults for the odometer scan sequencer
package odo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH_RST,
    ST_PH_REF,
    ST_PH_STR,
    ST_PH_CMP,
    ST_DONE
  } odo_state_e;

  localparam logic [1:0] MODE_RST = 2'b00;
  localparam logic [1:0] MODE_REF = 2'b01;
  localparam logic [1:0] MODE_STR = 2'b10;
  localparam logic [1:0] MODE_CMP = 2'b11;

  localparam logic [7:0] THRESH_DEFAULT = 8'd16;

endpackage

// File: rtl/odo_phase_timer.sv
// rtl/odo_phase_timer.sv - per-phase down counter with a last-cycle pulse
module odo_phase_timer #(
  parameter int PHASE_LEN = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic last_o
);

  localparam int CW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(PHASE_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/odo_cdir_sequencer.sv
// rtl/odo_cdir_sequencer.sv - steps each odometer through reset/reference/stress/compare
// phases and captures the decoder's frequency difference at the end of compare.
module odo_cdir_sequencer
  import odo_pkg::*;
#(
  parameter int         NUM_ODO   = 2,
  parameter int         PHASE_LEN = 120,
  parameter logic [7:0] THRESH    = THRESH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] freq_diff,
  output logic [1:0] mode,
  output logic [2:0] ODO_SEL_MUX,
  output logic       busy,
  output logic       diff_valid,
  output logic [7:0] diff_out,
  output logic [2:0] diff_idx,
  output logic [7:0] max_diff,
  output logic       recycled,
  output logic       done
);

  localparam logic [2:0] LAST_ODO = 3'(NUM_ODO - 1);

  odo_state_e state_q;
  logic [1:0] mode_q;
  logic [2:0] sel_q;
  logic       busy_q;
  logic       diff_valid_q;
  logic [7:0] diff_out_q;
  logic [2:0] diff_idx_q;
  logic [7:0] max_diff_q;
  logic       recycled_q;
  logic       done_q;

  logic       phase_last;
  logic       timer_load;

  // Holding the timer loaded outside the phases means every phase entry starts a full count.
  assign timer_load = (state_q == ST_IDLE) || (state_q == ST_DONE) || phase_last;

  odo_phase_timer #(
    .PHASE_LEN(PHASE_LEN)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(timer_load),
    .last_o(phase_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_RST;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      diff_valid_q <= 1'b0;
      diff_out_q   <= '0;
      diff_idx_q   <= '0;
      max_diff_q   <= '0;
      recycled_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      diff_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_PH_RST;
            mode_q     <= MODE_RST;
            busy_q     <= 1'b1;
            sel_q      <= '0;
            max_diff_q <= '0;
            recycled_q <= 1'b0;
          end
        end
        ST_PH_RST, ST_PH_REF, ST_PH_STR, ST_PH_CMP: begin
          if (abort) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RST;
            busy_q  <= 1'b0;
          end else if (phase_last) begin
            case (state_q)
              ST_PH_RST: begin
                state_q <= ST_PH_REF;
                mode_q  <= MODE_REF;
              end
              ST_PH_REF: begin
                state_q <= ST_PH_STR;
                mode_q  <= MODE_STR;
              end
              ST_PH_STR: begin
                state_q <= ST_PH_CMP;
                mode_q  <= MODE_CMP;
              end
              default: begin
                diff_valid_q <= 1'b1;
                diff_out_q   <= freq_diff;
                diff_idx_q   <= sel_q;
                if (freq_diff > max_diff_q) begin
                  max_diff_q <= freq_diff;
                end
                if (freq_diff > THRESH) begin
                  recycled_q <= 1'b1;
                end
                mode_q <= MODE_RST;
                if (sel_q < LAST_ODO) begin
                  sel_q   <= sel_q + 3'd1;
                  state_q <= ST_PH_RST;
                end else begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          mode_q  <= MODE_RST;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mode        = mode_q;
  assign ODO_SEL_MUX = sel_q;
  assign busy        = busy_q;
  assign diff_valid  = diff_valid_q;
  assign diff_out    = diff_out_q;
  assign diff_idx    = diff_idx_q;
  assign max_diff    = max_diff_q;
  assign recycled    = recycled_q;
  assign done        = done_q;

endmodule
